// File: rtl/demux4_dispatcher.sv
// Handshake-to-demux sequencer: latches upstream bytes onto the demux data bus
// and steers them to one of four channels by round-robin or a fixed select.
module demux4_dispatcher #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  input  logic             mode,
  input  logic [1:0]       cfg_sel,
  input  logic [3:0]       chan_en,
  input  logic [3:0]       out_ready,
  output logic [7:0]       A,
  output logic [1:0]       S,
  output logic [3:0]       out_valid,
  output logic [CNT_W-1:0] tx_count
);

  typedef enum logic {IDLE, SEND} state_e;

  state_e           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [7:0]       a_q, a_d;
  logic [1:0]       s_q, s_d;
  logic [3:0]       out_valid_q, out_valid_d;
  logic [CNT_W-1:0] tx_count_q, tx_count_d;

  logic [1:0] rr_sel, rr_idx, sel;
  logic       rr_found, can_pick, done, accept;

  // Round-robin scan starts one past the last grant and wraps through all four.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    rr_sel   = last_q;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      rr_idx = last_q + 2'(i);
      if (!rr_found && chan_en[rr_idx]) begin
        rr_sel   = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  assign sel      = mode ? cfg_sel : rr_sel;
  assign can_pick = mode | (|chan_en);
  assign done     = (state_q == SEND) && out_ready[s_q];
  // Combinational through out_ready so a completing byte can be replaced the same edge.
  assign in_ready = can_pick && ((state_q == IDLE) || done);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    a_d         = a_q;
    s_d         = s_q;
    out_valid_d = out_valid_q;
    tx_count_d  = tx_count_q;
    if (accept) begin
      a_d         = in_data;
      s_d         = sel;
      state_d     = SEND;
      out_valid_d = 4'b0001 << sel;
      if (!mode) last_d = sel;
    end else if (done) begin
      state_d     = IDLE;
      out_valid_d = 4'b0000;
    end
    if (done) tx_count_d = tx_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 2'd3;
      a_q         <= '0;
      s_q         <= '0;
      out_valid_q <= '0;
      tx_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      a_q         <= a_d;
      s_q         <= s_d;
      out_valid_q <= out_valid_d;
      tx_count_q  <= tx_count_d;
    end
  end

  assign A         = a_q;
  assign S         = s_q;
  assign out_valid = out_valid_q;
  assign tx_count  = tx_count_q;

endmodule

// File: tb/tb_demux4_dispatcher.sv
// Scoreboard bench for demux4_dispatcher: accepted bytes are queued with their
// expected channel and checked when the dispatcher completes them.
module tb_demux4_dispatcher;

  localparam int CNT_W = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_ready;
  logic             mode;
  logic [1:0]       cfg_sel;
  logic [3:0]       chan_en;
  logic [3:0]       out_ready;
  logic [7:0]       A;
  logic [1:0]       S;
  logic [3:0]       out_valid;
  logic [CNT_W-1:0] tx_count;

  typedef struct {
    logic [7:0] data;
    logic [1:0] chan;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  demux4_dispatcher #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mode(mode), .cfg_sel(cfg_sel), .chan_en(chan_en),
    .out_ready(out_ready), .A(A), .S(S), .out_valid(out_valid), .tx_count(tx_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, act, exp, $time);
    end
  endtask

  // Completion monitor: a valid target with its ready high completes at the next edge.
  always @(negedge clk) begin
    if (!rst && out_valid != 4'b0000 && out_ready[S]) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("done_A", A, e.data);
        check("done_S", S, e.chan);
        check("done_ov", out_valid, 4'b0001 << e.chan);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    sb.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Present one byte until accepted (bounded), recording its expected channel.
  task automatic send(input logic [7:0] d, input logic [1:0] ch, output int stalls);
    bit got = 0;
    stalls   = 0;
    in_valid = 1'b1;
    in_data  = d;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{data: d, chan: ch});
        got = 1;
      end else begin
        stalls++;
      end
      @(posedge clk);
      #1;
    end
    if (!got) check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while (sb.size() != 0 && c < 40) begin
      @(posedge clk);
      c++;
    end
    check("drain", sb.size(), 0);
    #1;
  endtask

  logic [7:0] rr_data [5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
  logic [1:0] rr_chan [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [7:0] sp_data [3] = '{8'h01, 8'h02, 8'h03};
  logic [1:0] sp_chan [3] = '{2'd1, 2'd3, 2'd1};

  initial begin
    int st, total_st;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; mode = 1'b0;
    cfg_sel = '0; chan_en = 4'b1111; out_ready = 4'b1111;
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check("rst_A", A, 8'h00);
    check("rst_S", S, 2'd0);
    check("rst_ov", out_valid, 4'b0000);
    check("rst_cnt", tx_count, 0);
    check("rst_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // Round-robin stream on consecutive cycles.
    total_st = 0;
    for (int i = 0; i < 5; i++) begin
      send(rr_data[i], rr_chan[i], st);
      total_st += st;
    end
    check("rr_stalls", total_st, 0);
    drain();
    check("rr_cnt", tx_count, 5);

    // Sparse enable 1010 continuing from last grant 0.
    chan_en = 4'b1010;
    for (int i = 0; i < 3; i++) send(sp_data[i], sp_chan[i], st);
    drain();
    check("sp_cnt", tx_count, 8);

    // Backpressure on channel 1.
    chan_en = 4'b0010; out_ready = 4'b1101;
    send(8'hA5, 2'd1, st);
    in_valid = 1'b1; in_data = 8'hB6;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_A", A, 8'hA5);
      check("bp_S", S, 2'd1);
      check("bp_ov", out_valid, 4'b0010);
      check("bp_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    out_ready = 4'b1111;
    @(negedge clk);
    check("bp_release_ready", in_ready, 1'b1);
    if (in_ready) sb.push_back('{data: 8'hB6, chan: 2'd1});
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_cnt", tx_count, 9);
    check("bp_b2b_A", A, 8'hB6);
    check("bp_b2b_ov", out_valid, 4'b0010);
    drain();
    check("bp_cnt2", tx_count, 10);

    // Fixed mode ignores chan_en.
    mode = 1'b1; cfg_sel = 2'd2; chan_en = 4'b0000;
    send(8'h7E, 2'd2, st);
    send(8'h7F, 2'd2, st);
    drain();
    mode = 1'b0;
    in_valid = 1'b1; in_data = 8'hEE;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("none_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("none_cnt", tx_count, 12);
    check("none_ov", out_valid, 4'b0000);

    // Reset while a byte is held.
    chan_en = 4'b1111;
    do_reset();
    out_ready = 4'b0000;
    send(8'h3C, 2'd0, st);
    @(negedge clk);
    check("held_ov", out_valid, 4'b0001);
    @(posedge clk); #1;
    do_reset();
    @(negedge clk);
    check("mid_rst_ov", out_valid, 4'b0000);
    check("mid_rst_cnt", tx_count, 0);
    check("mid_rst_A", A, 8'h00);
    check("mid_rst_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    out_ready = 4'b1111;
    chan_en = 4'b1011;
    send(8'h5A, 2'd0, st);
    drain();
    check("post_rst_cnt", tx_count, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
